// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (IF / LS) arbiter in front of one single-port memory
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   if_req/if_addr                instruction fetch read request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata     IF grant pulse, completion pulse and read data
//   ls_req/ls_we/ls_be/ls_addr/ls_wdata  load/store request, held until ls_gnt
//   ls_gnt/ls_rvalid/ls_rdata     LS grant pulse, completion pulse and read data
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  memory request, held until mem_ready
//   mem_ready/mem_rvalid/mem_rdata            memory accept, completion and read data
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [3:0]        ls_be,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner_ls;
    logic [3:0]        starve_cnt;
    logic [3:0]        starve_nxt;
    logic              grant_if;
    logic              grant_ls;
    logic              if_gnt_q;
    logic              ls_gnt_q;
    logic              mem_we_q;
    logic [3:0]        mem_be_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              done;

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        grant_if   = 1'b0;
        grant_ls   = 1'b0;
        case (state)
            IDLE: begin
                // LS normally wins; IF is forced through once it has lost
                // STARVE_MAX arbitrations in a row.
                if (if_req && (!ls_req || starve_cnt == STARVE_LIM)) begin
                    grant_if = 1'b1;
                end else if (ls_req) begin
                    grant_ls = 1'b1;
                end
                if (grant_if || grant_ls) begin
                    state_nxt = REQ;
                end
                if (grant_if || !if_req) begin
                    starve_nxt = 4'd0;
                end else if (grant_ls && starve_cnt != STARVE_LIM) begin
                    starve_nxt = starve_cnt + 4'd1;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner_ls    <= 1'b0;
            starve_cnt  <= 4'd0;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if_gnt_q   <= grant_if;
            ls_gnt_q   <= grant_ls;
            if (grant_ls) begin
                owner_ls    <= 1'b1;
                mem_we_q    <= ls_we;
                mem_be_q    <= ls_be;
                mem_addr_q  <= ls_addr;
                mem_wdata_q <= ls_wdata;
            end else if (grant_if) begin
                owner_ls    <= 1'b0;
                mem_we_q    <= 1'b0;
                mem_be_q    <= 4'b1111;
                mem_addr_q  <= if_addr;
                mem_wdata_q <= '0;
            end
        end
    end

    // Completion is routed combinationally to the owner; gating with rst keeps
    // a completion from leaking out in the cycle reset is being applied.
    assign done      = !rst && (state == WAIT) && mem_rvalid;
    assign if_rvalid = done && !owner_ls;
    assign ls_rvalid = done && owner_ls;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

    assign if_gnt    = if_gnt_q;
    assign ls_gnt    = ls_gnt_q;
    assign mem_req   = !rst && (state == REQ);
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One IDLE cycle with no grant and no memory request, ending on the arbitration edge.
    task automatic idle_cycle(input string tag);
        @(negedge clk);
        check({tag, "_idle_if_gnt"}, if_gnt, 0);
        check({tag, "_idle_ls_gnt"}, ls_gnt, 0);
        check({tag, "_idle_mem_req"}, mem_req, 0);
        tick();
    endtask

    // Entered at the start of the grant (REQ) cycle. Holds mem_ready low for
    // 'delay' cycles, accepts, then completes one cycle later with 'rd'.
    task automatic serve(input string tag, input bit exp_ls, input logic [31:0] addr,
                         input bit we, input logic [3:0] be, input logic [31:0] wd,
                         input int delay, input logic [31:0] rd);
        for (int i = 0; i <= delay; i++) begin
            mem_ready = (i == delay);
            @(negedge clk);
            check({tag, "_if_gnt"}, if_gnt, (i == 0) && !exp_ls);
            check({tag, "_ls_gnt"}, ls_gnt, (i == 0) && exp_ls);
            check({tag, "_mem_req"}, mem_req, 1);
            check({tag, "_mem_addr"}, mem_addr, addr);
            check({tag, "_mem_we"}, mem_we, we);
            check({tag, "_mem_be"}, mem_be, be);
            check({tag, "_mem_wdata"}, mem_wdata, wd);
            check({tag, "_early_rvalid"}, {if_rvalid, ls_rvalid}, 0);
            tick();
        end
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        @(negedge clk);
        check({tag, "_wait_mem_req"}, mem_req, 0);
        check({tag, "_if_rvalid"}, if_rvalid, !exp_ls);
        check({tag, "_ls_rvalid"}, ls_rvalid, exp_ls);
        if (exp_ls) check({tag, "_ls_rdata"}, ls_rdata, rd);
        else        check({tag, "_if_rdata"}, if_rdata, rd);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    initial begin
        rst        = 1'b1;
        if_req     = 1'b1;
        if_addr    = 32'h0000_0004;
        ls_req     = 1'b1;
        ls_we      = 1'b0;
        ls_be      = 4'b1111;
        ls_addr    = 32'h0000_0100;
        ls_wdata   = 32'h0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick();

        // T1: reset with both requests high
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("t1_gnt", {if_gnt, ls_gnt}, 0);
            check("t1_rvalid", {if_rvalid, ls_rvalid}, 0);
            check("t1_mem_req", mem_req, 0);
            check("t1_mem_ctl", {mem_we, mem_be}, 0);
            check("t1_mem_addr", mem_addr, 0);
            check("t1_mem_wdata", mem_wdata, 0);
            check("t1_rdata", {if_rdata, ls_rdata}, 0);
            tick();
        end
        rst = 1'b0;
        idle_cycle("t1");

        // T3: simultaneous requests, LS first; T2: IF read on the next IDLE
        serve("t3_ls", 1, 32'h0000_0100, 0, 4'b1111, 32'h0, 0, 32'h1122_3344);
        ls_req = 1'b0;
        idle_cycle("t2");
        serve("t2_if", 0, 32'h0000_0004, 0, 4'b1111, 32'h0, 0, 32'h00A0_0093);
        if_req = 1'b0;

        // No requests: stays idle
        for (int c = 0; c < 3; c++) idle_cycle("noreq");

        // T4: starvation with STARVE_MAX=4
        if_req  = 1'b1;
        if_addr = 32'h0000_0008;
        ls_req  = 1'b1;
        ls_addr = 32'h0000_0200;
        idle_cycle("t4");
        for (int k = 0; k < 4; k++) begin
            serve($sformatf("t4_ls%0d", k), 1, 32'h0000_0200 + 32'(4 * k), 0, 4'b1111,
                  32'h0, 0, 32'hA000_0000 + 32'(k));
            ls_addr = ls_addr + 32'd4;
            idle_cycle($sformatf("t4_%0d", k));
        end
        serve("t4_if", 0, 32'h0000_0008, 0, 4'b1111, 32'h0, 0, 32'h0000_0013);
        idle_cycle("t4_resume");
        serve("t4_ls_resume", 1, 32'h0000_0210, 0, 4'b1111, 32'h0, 0, 32'h0000_0077);
        if_req = 1'b0;
        ls_req = 1'b0;

        // T5: LS write with mem_ready held low 3 cycles
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_be    = 4'b0011;
        ls_addr  = 32'h0000_0010;
        ls_wdata = 32'hDEAD_BEEF;
        idle_cycle("t5");
        serve("t5_wr", 1, 32'h0000_0010, 1, 4'b0011, 32'hDEAD_BEEF, 3, 32'h0);
        ls_req = 1'b0;
        ls_we  = 1'b0;
        ls_be  = 4'b1111;

        // T6: reset while waiting, late completion ignored
        if_req  = 1'b1;
        if_addr = 32'h0000_0020;
        idle_cycle("t6");
        mem_ready = 1'b1;
        @(negedge clk);
        check("t6_if_gnt", if_gnt, 1);
        check("t6_mem_req", mem_req, 1);
        tick();
        mem_ready = 1'b0;
        if_req    = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("t6_rst_rvalid", {if_rvalid, ls_rvalid}, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_after_rst_mem_req", mem_req, 0);
        check("t6_after_rst_rvalid", {if_rvalid, ls_rvalid}, 0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        check("t6_late_rvalid", {if_rvalid, ls_rvalid}, 0);
        check("t6_late_gnt", {if_gnt, ls_gnt}, 0);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if_req     = 1'b1;
        if_addr    = 32'h0000_0024;
        idle_cycle("t6_next");
        serve("t6_if", 0, 32'h0000_0024, 0, 4'b1111, 32'h0, 1, 32'h0000_0055);
        if_req = 1'b0;
        idle_cycle("end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
